// File: rtl/classificador_frase.sv
// Phrase classifier: debounces the "ok" push-button into one-cycle note events and
// walks a phrase grammar (prefix, key note, ending) to report adjective/comparative/adverb.
module classificador_frase #(
    parameter int N_PREFIX       = 2,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ok,
    input  logic       tom,
    input  logic [2:0] nota,
    output logic       fim,
    output logic [1:0] tipo,
    output logic [3:0] notas,
    output logic [6:0] display
);

    typedef enum logic [3:0] {
        INICIAL, PREFIXO, CHAVE_LA, CHAVE_SI, FIM_DO, FIM_RE, FIM_SI, ADJ, COMP, ADV, ERRO
    } estado_t;

    estado_t     estado, prox, base;
    logic [3:0]  notas_prox, nbase;
    logic [23:0] cnt, cnt_prox;
    logic        sync1, sync2, hist, vivo, armado;
    logic        evento, pausa;
    logic [3:0]  codigo;

    // armado only rises once a low level of ok has been sampled after reset, so a
    // button held through reset release cannot fire until it is released.
    assign evento = sync2 & ~hist & armado;
    assign pausa  = (nota == 3'b000);
    assign codigo = {tom, nota};

    function automatic logic [3:0] inc(input logic [3:0] n);
        return (n == 4'd15) ? n : n + 4'd1;
    endfunction

    function automatic logic terminal(input estado_t e);
        return e inside {ADJ, COMP, ADV, ERRO};
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] seg(input estado_t e, input logic [3:0] n);
        case (e)
            ADJ:     return 7'b0001000;
            COMP:    return 7'b1000110;
            ADV:     return 7'b0100001;
            ERRO:    return 7'b0000110;
            default: return hex7(n);
        endcase
    endfunction

    function automatic logic [1:0] classe(input estado_t e);
        case (e)
            ADJ:     return 2'b01;
            COMP:    return 2'b10;
            ADV:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        prox       = estado;
        notas_prox = notas;
        cnt_prox   = '0;
        base       = estado;
        nbase      = notas;
        // A finished phrase restarts as if from INICIAL with the new event.
        if (terminal(estado)) begin
            base  = INICIAL;
            nbase = '0;
        end
        if (evento) begin
            notas_prox = pausa ? nbase : inc(nbase);
            case (base)
                INICIAL: prox = pausa ? ERRO : PREFIXO;
                PREFIXO: begin
                    prox = PREFIXO;
                    if (pausa)                         prox = ERRO;
                    else if (nbase == 4'(N_PREFIX)) begin
                        if (codigo == 4'b0110)         prox = CHAVE_LA;
                        else if (codigo == 4'b1111)    prox = CHAVE_SI;
                        else                           prox = ERRO;
                    end
                end
                CHAVE_LA: begin
                    if (pausa)                  prox = ADJ;
                    else if (codigo == 4'b0001) prox = FIM_DO;
                    else if (codigo == 4'b1111) prox = FIM_SI;
                    else                        prox = ERRO;
                end
                CHAVE_SI: begin
                    if (pausa)                  prox = ADJ;
                    else if (codigo == 4'b0010) prox = FIM_RE;
                    else                        prox = ERRO;
                end
                FIM_DO, FIM_RE: prox = pausa ? COMP : ERRO;
                FIM_SI:         prox = pausa ? ADV : ERRO;
                default: begin
                    prox       = INICIAL;
                    notas_prox = '0;
                end
            endcase
        end else if (estado inside {PREFIXO, CHAVE_LA, CHAVE_SI, FIM_DO, FIM_RE, FIM_SI}) begin
            cnt_prox = cnt + 24'd1;
            if (cnt_prox == 24'(TIMEOUT_CICLOS)) begin
                prox     = ERRO;
                cnt_prox = '0;
            end
        end else if (!terminal(estado) && estado != INICIAL) begin
            prox       = INICIAL;
            notas_prox = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            hist    <= 1'b0;
            vivo    <= 1'b0;
            armado  <= 1'b0;
            estado  <= INICIAL;
            notas   <= '0;
            cnt     <= '0;
            fim     <= 1'b0;
            tipo    <= 2'b00;
            display <= 7'b1000000;
        end else begin
            sync1   <= ok;
            sync2   <= sync1;
            hist    <= sync2;
            vivo    <= 1'b1;
            armado  <= armado | (vivo & ~sync1);
            estado  <= prox;
            notas   <= notas_prox;
            cnt     <= cnt_prox;
            fim     <= terminal(prox);
            tipo    <= classe(prox);
            display <= seg(prox, notas_prox);
        end
    end

endmodule

// File: tb/tb_classificador_frase.sv
// Bench for classificador_frase: two instances (prefix 2 and 4) checked every cycle
// against a phrase-level model, plus hand-computed literal expectations.
module tb_classificador_frase;

    localparam int TOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ok = 1'b0;
    logic       tom = 1'b0;
    logic [2:0] nota = 3'b000;
    logic       fim_a, fim_b;
    logic [1:0] tipo_a, tipo_b;
    logic [3:0] notas_a, notas_b;
    logic [6:0] disp_a, disp_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    classificador_frase #(.N_PREFIX(2), .TIMEOUT_CICLOS(TOUT)) dut_a (
        .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
        .fim(fim_a), .tipo(tipo_a), .notas(notas_a), .display(disp_a));

    classificador_frase #(.N_PREFIX(4), .TIMEOUT_CICLOS(TOUT)) dut_b (
        .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
        .fim(fim_b), .tipo(tipo_b), .notas(notas_b), .display(disp_b));

    logic [6:0] hexseg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: each instance keeps the notes of its current phrase as a list of codes.
    int npre [2] = '{2, 4};
    int ph [2][16];
    int len [2];
    bit to_ [2];
    int idle [2];
    int run;
    bit seen_low, armed_run, started = 1'b0;

    // 0 = in progress, 1 = adjective, 2 = comparative, 3 = adverb, 4 = error
    function automatic int classify(input int m);
        int n, key, fin, c;
        n = npre[m]; key = 0; fin = 0;
        for (int i = 0; i < len[m]; i++) begin
            c = ph[m][i];
            if (i < n) begin
                if (c % 8 == 0) return 4;
            end else if (i == n) begin
                if (c == 6) key = 1;
                else if (c == 15) key = 2;
                else return 4;
            end else if (i == n + 1) begin
                if (c % 8 == 0) return 1;
                if (key == 1 && c == 1) fin = 2;
                else if (key == 1 && c == 15) fin = 3;
                else if (key == 2 && c == 2) fin = 2;
                else return 4;
            end else begin
                return (c % 8 == 0) ? fin : 4;
            end
        end
        return 0;
    endfunction

    function automatic int count(input int m);
        int n = 0;
        for (int i = 0; i < len[m]; i++)
            if (ph[m][i] % 8 != 0 && n < 15) n++;
        return n;
    endfunction

    function automatic void step(input int m, input bit ev, input int c);
        if (ev) begin
            if (classify(m) != 0 || to_[m]) begin
                len[m] = 0;
                to_[m] = 1'b0;
            end
            if (len[m] < 16) begin
                ph[m][len[m]] = c;
                len[m]++;
            end
            idle[m] = 0;
        end else if (len[m] > 0 && classify(m) == 0 && !to_[m]) begin
            idle[m]++;
            if (idle[m] == TOUT) to_[m] = 1'b1;
        end
    endfunction

    function automatic logic [13:0] expected(input int m);
        int k, n;
        logic [6:0] d;
        k = to_[m] ? 4 : classify(m);
        n = count(m);
        case (k)
            1: d = 7'b0001000;
            2: d = 7'b1000110;
            3: d = 7'b0100001;
            4: d = 7'b0000110;
            default: d = hexseg[n];
        endcase
        return {(k != 0), (k >= 1 && k <= 3) ? k[1:0] : 2'b00, n[3:0], d};
    endfunction

    // A note event is the third consecutive high sample of ok, provided that run of
    // highs was preceded by a low sample taken after reset release.
    always @(posedge clk) begin
        bit ev;
        ev = 1'b0;
        if (reset) begin
            run = 0; seen_low = 1'b0; armed_run = 1'b0; started = 1'b1;
            for (int m = 0; m < 2; m++) begin
                len[m] = 0; to_[m] = 1'b0; idle[m] = 0;
            end
        end else begin
            if (!ok) begin
                seen_low = 1'b1;
                run = 0;
            end else begin
                if (run == 0) armed_run = seen_low;
                if (run < 1000) run++;
                ev = (run == 3) && armed_run;
            end
            for (int m = 0; m < 2; m++) step(m, ev, int'({tom, nota}));
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_a", {18'd0, fim_a, tipo_a, notas_a, disp_a}, {18'd0, expected(0)});
            check("model_b", {18'd0, fim_b, tipo_b, notas_b, disp_b}, {18'd0, expected(1)});
        end
    end

    task automatic press(input bit t, input int nt);
        @(negedge clk);
        tom = t; nota = nt[2:0]; ok = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ok = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        check("reset_state", {fim_a, tipo_a, notas_a, disp_a}, {1'b0, 2'b00, 4'd0, 7'b1000000});

        // sol mi la pause -> adjective
        press(0, 5); press(0, 3); press(0, 6); press(0, 0);
        check("adj", {fim_a, tipo_a, notas_a, disp_a}, {1'b1, 2'b01, 4'd3, 7'b0001000});
        // do re si# re pause -> comparative
        press(0, 1); press(0, 2); press(1, 7); press(0, 2); press(0, 0);
        check("comp", {fim_a, tipo_a, notas_a, disp_a}, {1'b1, 2'b10, 4'd4, 7'b1000110});
        // do re la si# pause -> adverb
        press(0, 1); press(0, 2); press(0, 6); press(1, 7); press(0, 0);
        check("adv", {fim_a, tipo_a, notas_a, disp_a}, {1'b1, 2'b11, 4'd4, 7'b0100001});
        // pause first -> error, then fa restarts the phrase
        press(0, 0);
        check("pause_first", {fim_a, tipo_a, notas_a, disp_a}, {1'b1, 2'b00, 4'd0, 7'b0000110});
        press(0, 4);
        check("restart_fa", {fim_a, tipo_a, notas_a, disp_a}, {1'b0, 2'b00, 4'd1, 7'b1111001});

        // ok held for 200 cycles: exactly one event, on the third sampled edge
        do_reset();
        @(negedge clk);
        tom = 1'b0; nota = 3'd3; ok = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("hold_edge2", notas_a, 4'd0);
        @(posedge clk);
        #1 check("hold_edge3", notas_a, 4'd1);
        repeat (197) @(posedge clk);
        #1 check("hold_200", notas_a, 4'd1);
        @(negedge clk);
        ok = 1'b0;
        repeat (3) @(negedge clk);

        // timeout: error exactly TOUT cycles after the event
        do_reset();
        @(negedge clk);
        tom = 1'b0; nota = 3'd5; ok = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ok = 1'b0;
        repeat (TOUT - 1) @(posedge clk);
        #1 check("timeout_19", fim_a, 1'b0);
        @(posedge clk);
        #1 check("timeout_20", {fim_a, disp_a}, {1'b1, 7'b0000110});
        // a new event landing on the timeout edge wins
        @(negedge clk);
        nota = 3'd1; ok = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ok = 1'b0;
        repeat (TOUT - 3) @(posedge clk);
        @(negedge clk);
        nota = 3'd2; ok = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("event_on_20", {fim_a, notas_a}, {1'b0, 4'd2});
        @(negedge clk);
        ok = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-phrase, then ok held across reset release
        do_reset();
        press(0, 1); press(0, 2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("reset_mid", {fim_a, tipo_a, notas_a, disp_a}, {1'b0, 2'b00, 4'd0, 7'b1000000});
        @(negedge clk);
        ok = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("held_reset", {fim_a, notas_a, fim_b, notas_b}, 10'd0);
        ok = 1'b0;
        repeat (3) @(negedge clk);

        // do re mi fa la pause: adjective for prefix 4, error for prefix 2
        press(0, 1); press(0, 2); press(0, 3); press(0, 4); press(0, 6); press(0, 0);
        check("n4_adj", {fim_b, tipo_b, notas_b, disp_b}, {1'b1, 2'b01, 4'd5, 7'b0001000});
        check("n2_err", {fim_a, tipo_a, notas_a, disp_a}, {1'b1, 2'b00, 4'd2, 7'b0000110});

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
